shift_sequencer: RTL and testbench

Controller that sequences the 8-bit load/shift register (2-bit shift command: 00 hold, 01 shift right toward bit 0 with D0 entering bit 7, 10 shift left with D0 entering bit 0, 11 load).
- Accepts a shift request (operand, direction, mode, amount) over a start/busy/done handshake.
- Loads the register, issues exactly `amount` single-bit shift commands, drives the fill bit each cycle, then returns the result and the last bit shifted out.
- Sits between the ALU opcode decoder and the shift register. It is the only block that drives the register's command inputs.

---
 rtl/shift_sequencer.sv | 147 ++++++++++++++
 tb/tb_shift_sequencer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/shift_sequencer.sv
// ============================================================================
// shift_sequencer: load/shift/done sequencer for the 8-bit shift register
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_sequencer #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [WIDTH-1:0] operand,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic [AMT_W-1:0] amount,
  input  logic [WIDTH-1:0] reg_q,
  output logic [WIDTH-1:0] reg_load_data,
  output logic [1:0]       reg_shift,
  output logic             reg_d0,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [1:0] CMD_HOLD  = 2'b00;
  localparam logic [1:0] CMD_RIGHT = 2'b01;
  localparam logic [1:0] CMD_LEFT  = 2'b10;
  localparam logic [1:0] CMD_LOAD  = 2'b11;

  state_t           state_q;
  logic [WIDTH-1:0] load_data_q;
  logic             dir_q;
  logic [1:0]       mode_q;
  logic [AMT_W-1:0] cnt_q;
  logic [1:0]       reg_shift_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] result_q;
  logic             carry_q;

  logic             fill_d;
  logic [WIDTH-1:0] shifted_d;
  logic             out_bit_d;

  always_comb begin
    fill_d = 1'b0;
    if (state_q == S_SHIFT) begin
      if (!dir_q) begin
        case (mode_q)
          2'b01:   fill_d = reg_q[WIDTH-1];
          2'b10:   fill_d = reg_q[0];
          default: fill_d = 1'b0;
        endcase
      end else begin
        fill_d = (mode_q == 2'b10) ? reg_q[WIDTH-1] : 1'b0;
      end
    end
  end

  // Value the register will hold after this cycle's shift; lets result be
  // registered on entry to DONE so it is visible in the done cycle itself.
  assign shifted_d = dir_q ? {reg_q[WIDTH-2:0], fill_d} : {fill_d, reg_q[WIDTH-1:1]};
  assign out_bit_d = dir_q ? reg_q[WIDTH-1] : reg_q[0];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      load_data_q <= '0;
      dir_q       <= 1'b0;
      mode_q      <= 2'b00;
      cnt_q       <= '0;
      reg_shift_q <= CMD_HOLD;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      result_q    <= '0;
      carry_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            load_data_q <= operand;
            dir_q       <= dir;
            mode_q      <= mode;
            cnt_q       <= amount;
            reg_shift_q <= CMD_LOAD;
            busy_q      <= 1'b1;
            state_q     <= S_LOAD;
          end
        end
        S_LOAD: begin
          carry_q <= 1'b0;
          if (cnt_q == '0) begin
            reg_shift_q <= CMD_HOLD;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            result_q    <= load_data_q;
            state_q     <= S_DONE;
          end else begin
            reg_shift_q <= dir_q ? CMD_LEFT : CMD_RIGHT;
            state_q     <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          carry_q <= out_bit_d;
          cnt_q   <= cnt_q - AMT_W'(1);
          if (cnt_q == AMT_W'(1)) begin
            reg_shift_q <= CMD_HOLD;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            result_q    <= shifted_d;
            state_q     <= S_DONE;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          reg_shift_q <= CMD_HOLD;
          busy_q      <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign reg_load_data = load_data_q;
  assign reg_shift     = reg_shift_q;
  assign reg_d0        = fill_d;
  assign busy          = busy_q;
  assign done          = done_q;
  assign result        = result_q;
  assign carry_out     = carry_q;

endmodule

`default_nettype wire

// File: tb/tb_shift_sequencer.sv
// ============================================================================
// tb_shift_sequencer: directed table-driven bench with a shift register model
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shift_sequencer;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0;
  logic [7:0] operand = '0;
  logic       dir = 1'b0;
  logic [1:0] mode = '0;
  logic [2:0] amount = '0;
  logic [7:0] reg_q;
  logic [7:0] reg_load_data;
  logic [1:0] reg_shift;
  logic       reg_d0;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic       carry_out;

  int checks = 0;
  int failures = 0;

  shift_sequencer #(.WIDTH(8), .AMT_W(3)) dut (
    .clk(clk), .resetn(resetn), .start(start), .operand(operand), .dir(dir),
    .mode(mode), .amount(amount), .reg_q(reg_q), .reg_load_data(reg_load_data),
    .reg_shift(reg_shift), .reg_d0(reg_d0), .busy(busy), .done(done),
    .result(result), .carry_out(carry_out)
  );

  always #5 clk = ~clk;

  // The controlled 8-bit load/shift register, sharing resetn.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) reg_q <= '0;
    else begin
      case (reg_shift)
        2'b01:   reg_q <= {reg_d0, reg_q[7:1]};
        2'b10:   reg_q <= {reg_q[6:0], reg_d0};
        2'b11:   reg_q <= reg_load_data;
        default: reg_q <= reg_q;
      endcase
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] op;
    logic       d;
    logic [1:0] m;
    logic [2:0] a;
    logic [7:0] exp_res;
    logic       exp_cy;
  } vec_t;

  task automatic run_req(input string nm, input vec_t v);
    int done_cyc = -1;
    int nshift = 0, nload = 0, bad_cmd = 0, ndone = 0, overlap = 0;
    logic [7:0] res = '0;
    logic       cy = 1'b0;
    logic [1:0] exp_cmd;
    @(negedge clk);
    start = 1'b1; operand = v.op; dir = v.d; mode = v.m; amount = v.a;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      start = 1'b0; operand = ~v.op; dir = ~v.d; mode = ~v.m; amount = ~v.a;
      if (busy && done) overlap++;
      if (reg_shift == 2'b11) nload++;
      if (reg_shift == 2'b01 || reg_shift == 2'b10) nshift++;
      if (done_cyc < 0 && c <= int'(v.a) + 1) begin
        exp_cmd = (c == 1) ? 2'b11 : (v.d ? 2'b10 : 2'b01);
        if (reg_shift !== exp_cmd) bad_cmd++;
      end
      if (done) begin
        ndone++;
        if (done_cyc < 0) begin
          done_cyc = c; res = result; cy = carry_out;
        end
      end
    end
    chk({nm, " done_cycle"}, done_cyc, int'(v.a) + 2);
    chk({nm, " result"}, {24'd0, res}, {24'd0, v.exp_res});
    chk({nm, " carry"}, {31'd0, cy}, {31'd0, v.exp_cy});
    chk({nm, " shift_cmds"}, nshift, int'(v.a));
    chk({nm, " load_cmds"}, nload, 1);
    chk({nm, " cmd_seq_errs"}, bad_cmd, 0);
    chk({nm, " done_pulses"}, ndone, 1);
    chk({nm, " busy_done_overlap"}, overlap, 0);
    chk({nm, " result_held"}, {24'd0, result}, {24'd0, v.exp_res});
  endtask

  vec_t vecs[10];

  initial begin
    int busy_err, ndone;
    logic [7:0] res1, res2;
    logic cy1, cy2;

    vecs[0] = '{8'h96, 1'b0, 2'b00, 3'd3, 8'h12, 1'b1};
    vecs[1] = '{8'h96, 1'b0, 2'b01, 3'd2, 8'hE5, 1'b1};
    vecs[2] = '{8'h81, 1'b1, 2'b10, 3'd1, 8'h03, 1'b1};
    vecs[3] = '{8'h96, 1'b0, 2'b10, 3'd7, 8'h2D, 1'b0};
    vecs[4] = '{8'h5A, 1'b0, 2'b00, 3'd0, 8'h5A, 1'b0};
    vecs[5] = '{8'hFF, 1'b1, 2'b00, 3'd7, 8'h80, 1'b1};
    vecs[6] = '{8'h96, 1'b0, 2'b11, 3'd1, 8'h4B, 1'b0};
    vecs[7] = '{8'h81, 1'b1, 2'b01, 3'd2, 8'h04, 1'b0};
    vecs[8] = '{8'h7C, 1'b0, 2'b01, 3'd3, 8'h0F, 1'b1};
    vecs[9] = '{8'h96, 1'b1, 2'b10, 3'd7, 8'h4B, 1'b1};

    #12;
    chk("reset_outputs", {16'd0, reg_shift, reg_d0, busy, done, carry_out, reg_load_data},
        32'd0);
    chk("reset_result", {24'd0, result}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;

    for (int i = 0; i < 10; i++) run_req($sformatf("vec%0d", i), vecs[i]);

    // Start held high across a busy request with different inputs presented.
    busy_err = 0; ndone = 0;
    res1 = '0; res2 = '0; cy1 = 1'b0; cy2 = 1'b0;
    @(negedge clk);
    start = 1'b1; operand = 8'h96; dir = 1'b0; mode = 2'b00; amount = 3'd3;
    for (int c = 1; c <= 17; c++) begin
      @(negedge clk);
      if (busy !== (((c >= 1) && (c <= 4)) || ((c >= 7) && (c <= 14)))) busy_err++;
      if (done) ndone++;
      if (c == 5) begin res1 = result; cy1 = carry_out; chk("hs_done_c5", {31'd0, done}, 32'd1); end
      if (c == 15) begin res2 = result; cy2 = carry_out; chk("hs_done_c15", {31'd0, done}, 32'd1); end
      if (c == 1) begin operand = 8'hFF; dir = 1'b1; amount = 3'd7; end
      if (c == 7) start = 1'b0;
    end
    chk("hs_busy_pattern", busy_err, 0);
    chk("hs_done_count", ndone, 2);
    chk("hs_result1", {24'd0, res1}, 32'h12);
    chk("hs_carry1", {31'd0, cy1}, 32'd1);
    chk("hs_result2", {24'd0, res2}, 32'h80);
    chk("hs_carry2", {31'd0, cy2}, 32'd1);

    // Asynchronous reset in the middle of an amount-6 request.
    @(negedge clk);
    start = 1'b1; operand = 8'h96; dir = 1'b0; mode = 2'b00; amount = 3'd6;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_pre_busy", {31'd0, busy}, 32'd1);
    #1 resetn = 1'b0;
    #1;
    chk("rst_mid_outputs", {16'd0, reg_shift, reg_d0, busy, done, carry_out, reg_load_data},
        32'd0);
    chk("rst_mid_result", {24'd0, result}, 32'd0);
    ndone = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    resetn = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("rst_no_done", ndone, 0);
    run_req("post_reset", vecs[3]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
